// File: rtl/cd_cv_egress_buf_pkg.sv
// Shared definitions for the converge-crossbar egress buffer: lane count,
// lane indices and the default flit width.
package cd_cv_egress_buf_pkg;

  localparam int unsigned DATA_W_DEF = 64;
  localparam int unsigned LANES      = 2;
  localparam int unsigned LANE0      = 0;
  localparam int unsigned LANE1      = 1;

endpackage

// File: rtl/cd_sync_fifo.sv
// Single-clock FIFO with registered pointers/count and a head-of-queue read port.
// The caller guarantees push only when !full and pop only when !empty.
module cd_sync_fifo #(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1,
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = din;
      wptr_d        = wptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (pop) begin
      rptr_d = rptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the count clears
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rptr_q];
  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign count = cnt_q;

endmodule

// File: rtl/cd_cv_egress_buf.sv
// Two-lane egress buffer: per-lane FIFOs merged round-robin into one
// registered valid/ready output toward the node/mesh link.
module cd_cv_egress_buf
  import cd_cv_egress_buf_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [LANES-1:0]      cv_si,
  output logic [LANES-1:0]      cv_ro,
  input  logic [2*DATA_W-1:0]   cv_di,
  output logic                  out_so,
  input  logic                  out_ro,
  output logic [DATA_W-1:0]     out_do,
  output logic [CNT_W-1:0]      occ0,
  output logic [CNT_W-1:0]      occ1
);

  logic [LANES-1:0]  push_s, pop_s, empty_s, full_s;
  logic [DATA_W-1:0] head_s [LANES];
  logic [CNT_W-1:0]  cnt_s  [LANES];

  logic              rr_ptr_q, rr_ptr_d;
  logic              out_so_q, out_so_d;
  logic [DATA_W-1:0] out_do_q, out_do_d;
  logic              or_free_s, gnt_vld_s, gnt_lane_s;

  // Ready depends only on registered occupancy, so a full lane stays closed
  // even in a cycle where it also pops.
  assign cv_ro  = {reset & ~full_s[LANE1], reset & ~full_s[LANE0]};
  assign push_s = cv_si & cv_ro;

  cd_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push_s[LANE0]),
    .pop   (pop_s[LANE0]),
    .din   (cv_di[DATA_W-1:0]),
    .dout  (head_s[LANE0]),
    .empty (empty_s[LANE0]),
    .full  (full_s[LANE0]),
    .count (cnt_s[LANE0])
  );

  cd_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push_s[LANE1]),
    .pop   (pop_s[LANE1]),
    .din   (cv_di[2*DATA_W-1:DATA_W]),
    .dout  (head_s[LANE1]),
    .empty (empty_s[LANE1]),
    .full  (full_s[LANE1]),
    .count (cnt_s[LANE1])
  );

  // Round-robin grant and output-register reload
  always_comb begin
    pop_s      = '0;
    rr_ptr_d   = rr_ptr_q;
    out_so_d   = out_so_q;
    out_do_d   = out_do_q;
    gnt_vld_s  = 1'b0;
    gnt_lane_s = 1'b0;
    or_free_s  = ~out_so_q | out_ro;
    case (~empty_s)
      2'b01:   begin gnt_vld_s = 1'b1; gnt_lane_s = 1'b0;     end
      2'b10:   begin gnt_vld_s = 1'b1; gnt_lane_s = 1'b1;     end
      2'b11:   begin gnt_vld_s = 1'b1; gnt_lane_s = rr_ptr_q; end
      default: begin gnt_vld_s = 1'b0; gnt_lane_s = 1'b0;     end
    endcase
    if (or_free_s) begin
      if (gnt_vld_s) begin
        pop_s[gnt_lane_s] = 1'b1;
        out_so_d          = 1'b1;
        out_do_d          = head_s[gnt_lane_s];
        rr_ptr_d          = ~gnt_lane_s;
      end else begin
        out_so_d = 1'b0;
      end
    end else begin
      out_so_d = out_so_q;
    end
  end

  // Output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q <= 1'b0;
      out_so_q <= 1'b0;
      out_do_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      out_so_q <= out_so_d;
      out_do_q <= out_do_d;
    end
  end

  assign out_so = out_so_q;
  assign out_do = out_do_q;
  assign occ0   = cnt_s[LANE0];
  assign occ1   = cnt_s[LANE1];

endmodule

// File: tb/tb_cd_cv_egress_buf.sv
// Directed bench for cd_cv_egress_buf: a vector table for single-lane
// latency/full/drain behaviour plus sequences for contention, wrap and reset.
module tb_cd_cv_egress_buf;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   cv_si;
  logic [1:0]   cv_ro;
  logic [127:0] cv_di;
  logic         out_so;
  logic         out_ro;
  logic [63:0]  out_do;
  logic [2:0]   occ0, occ1;

  int n_total = 0;
  int n_pass  = 0;

  cd_cv_egress_buf dut (
    .clk    (clk),
    .reset  (reset),
    .cv_si  (cv_si),
    .cv_ro  (cv_ro),
    .cv_di  (cv_di),
    .out_so (out_so),
    .out_ro (out_ro),
    .out_do (out_do),
    .occ0   (occ0),
    .occ1   (occ1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] si;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       oro;
    logic [1:0] ro;
    logic       so;
    logic       cdo;
    logic [7:0] dout;
    logic [2:0] o0;
    logic [2:0] o1;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0; cv_si = 2'b00; cv_di = '0; out_ro = 1'b1;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    reset  = v.rst;
    cv_si  = v.si;
    cv_di  = {56'h0, v.d1, 56'h0, v.d0};
    out_ro = v.oro;
    #1;
    chk($sformatf("v%0d_cv_ro", idx), {62'h0, cv_ro}, {62'h0, v.ro});
    step();
    chk($sformatf("v%0d_out_so", idx), {63'h0, out_so}, {63'h0, v.so});
    chk($sformatf("v%0d_occ0", idx), {61'h0, occ0}, {61'h0, v.o0});
    chk($sformatf("v%0d_occ1", idx), {61'h0, occ1}, {61'h0, v.o1});
    if (v.cdo) chk($sformatf("v%0d_out_do", idx), out_do, {56'h0, v.dout});
  endtask

  initial begin
    logic [7:0] k0, k1, w, exp_b;
    logic [1:0] acc;
    logic       xfer;
    logic [7:0] xd;
    logic [2:0] max_occ0;
    int         sent, stale;
    logic [7:0] got [$];

    reset = 1'b0; cv_si = 2'b00; cv_di = '0; out_ro = 1'b1;

    // reset, single flit latency, lane0 fill with stalled egress, full-lane pop, drain
    tbl[0]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0};
    tbl[1]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0};
    tbl[2]  = '{1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 1'b0, 1'b1, 8'h00, 3'd0, 3'd0};
    tbl[3]  = '{1'b1, 2'b01, 8'hA1, 8'h00, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 3'd1, 3'd0};
    tbl[4]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b1, 1'b1, 8'hA1, 3'd0, 3'd0};
    tbl[5]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0};
    tbl[6]  = '{1'b1, 2'b01, 8'h30, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 3'd1, 3'd0};
    tbl[7]  = '{1'b1, 2'b01, 8'h31, 8'h00, 1'b0, 2'b11, 1'b1, 1'b1, 8'h30, 3'd1, 3'd0};
    tbl[8]  = '{1'b1, 2'b01, 8'h32, 8'h00, 1'b0, 2'b11, 1'b1, 1'b1, 8'h30, 3'd2, 3'd0};
    tbl[9]  = '{1'b1, 2'b01, 8'h33, 8'h00, 1'b0, 2'b11, 1'b1, 1'b1, 8'h30, 3'd3, 3'd0};
    tbl[10] = '{1'b1, 2'b01, 8'h34, 8'h00, 1'b0, 2'b11, 1'b1, 1'b1, 8'h30, 3'd4, 3'd0};
    tbl[11] = '{1'b1, 2'b01, 8'h35, 8'h00, 1'b0, 2'b10, 1'b1, 1'b1, 8'h30, 3'd4, 3'd0};
    tbl[12] = '{1'b1, 2'b01, 8'h35, 8'h00, 1'b1, 2'b10, 1'b1, 1'b1, 8'h31, 3'd3, 3'd0};
    tbl[13] = '{1'b1, 2'b01, 8'h35, 8'h00, 1'b0, 2'b11, 1'b1, 1'b1, 8'h31, 3'd4, 3'd0};
    tbl[14] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 2'b10, 1'b1, 1'b1, 8'h32, 3'd3, 3'd0};
    tbl[15] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b1, 1'b1, 8'h33, 3'd2, 3'd0};
    tbl[16] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b1, 1'b1, 8'h34, 3'd1, 3'd0};
    tbl[17] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b1, 1'b1, 8'h35, 3'd0, 3'd0};
    tbl[18] = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0};

    for (int i = 0; i < 19; i++) apply_vec(tbl[i], i);

    // both lanes push every cycle; egress alternates starting with lane0
    reset_dut();
    k0 = 8'h10; k1 = 8'h20; max_occ0 = 3'd0;
    got.delete();
    for (int c = 0; c < 24; c++) begin
      cv_si = 2'b11; cv_di = {56'h0, k1, 56'h0, k0}; out_ro = 1'b1;
      #1;
      if (c >= 10) chk($sformatf("t2_one_accept_c%0d", c), 64'($countones(cv_ro)), 64'd1);
      acc = cv_si & cv_ro;
      step();
      if (acc[0]) k0 = k0 + 8'h01;
      if (acc[1]) k1 = k1 + 8'h01;
      if (occ0 > max_occ0) max_occ0 = occ0;
      if (out_so) got.push_back(out_do[7:0]);
    end
    cv_si = 2'b00;
    chk("t2_lane0_full", {61'h0, max_occ0}, 64'd4);
    chk("t2_flit_count_ge16", {63'h0, got.size() >= 16}, 64'd1);
    for (int i = 0; i < 16 && i < got.size(); i++) begin
      exp_b = ((i % 2) == 0) ? 8'h10 + 8'(i / 2) : 8'h20 + 8'(i / 2);
      chk($sformatf("t2_flit%0d", i), {56'h0, got[i]}, {56'h0, exp_b});
    end

    // lane1 streams 10 words while out_ro toggles; order preserved through wrap
    reset_dut();
    w = 8'h50; sent = 0;
    got.delete();
    for (int c = 0; c < 80 && got.size() < 10; c++) begin
      cv_si = (sent < 10) ? 2'b10 : 2'b00;
      cv_di = {56'h0, w, 64'h0};
      out_ro = ((c % 2) == 0);
      #1;
      acc  = cv_si & cv_ro;
      xfer = out_so & out_ro;
      xd   = out_do[7:0];
      step();
      if (acc[1]) begin w = w + 8'h01; sent++; end
      if (xfer) got.push_back(xd);
    end
    cv_si = 2'b00;
    chk("t5_flit_count", 64'(got.size()), 64'd10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      chk($sformatf("t5_flit%0d", i), {56'h0, got[i]}, {56'h0, 8'h50 + 8'(i)});

    // mid-operation reset with buffered flits and a valid output register
    reset_dut();
    out_ro = 1'b0; cv_si = 2'b11; cv_di = {56'h0, 8'h70, 56'h0, 8'h60};
    step(); step(); step();
    chk("t6_pre_out_so", {63'h0, out_so}, 64'd1);
    chk("t6_pre_occ0", {61'h0, occ0}, 64'd2);
    chk("t6_pre_occ1", {61'h0, occ1}, 64'd3);
    reset = 1'b0;
    #1;
    chk("t6_cv_ro_in_reset", {62'h0, cv_ro}, 64'd0);
    step();
    chk("t6_out_so_cleared", {63'h0, out_so}, 64'd0);
    chk("t6_out_do_cleared", out_do, 64'd0);
    chk("t6_occ0_cleared", {61'h0, occ0}, 64'd0);
    chk("t6_occ1_cleared", {61'h0, occ1}, 64'd0);
    reset = 1'b1; cv_si = 2'b00; out_ro = 1'b1;
    #1;
    chk("t6_cv_ro_after", {62'h0, cv_ro}, 64'd3);
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (out_so !== 1'b0) stale++;
    end
    chk("t6_no_stale_flit", 64'(stale), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
